// File: rtl/iter_alu_pkg.sv
// Shared types for the iterative ALU stage: opcode and FSM encodings plus
// the shift-op classifier used by the top level.
package iter_alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD    = 4'd0,
    OP_SUB    = 4'd1,
    OP_AND    = 4'd2,
    OP_OR     = 4'd3,
    OP_XOR    = 4'd4,
    OP_NOR    = 4'd5,
    OP_NOT_A  = 4'd6,
    OP_PASS_A = 4'd7,
    OP_PASS_B = 4'd8,
    OP_LUI    = 4'd9,
    OP_SLT    = 4'd10,
    OP_SGT    = 4'd11,
    OP_SLTU   = 4'd12,
    OP_SLL    = 4'd13,
    OP_SRL    = 4'd14,
    OP_SRA    = 4'd15
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic is_shift(input alu_op_t op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/iter_alu_if.sv
// Operand-side and result-side valid/ready bundle of the ALU stage.
interface iter_alu_if
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  alu_op_t          op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             carry;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, zero, carry, ovf, illegal
  );

  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, zero, carry, ovf, illegal
  );
endinterface

// File: rtl/iter_alu_comb.sv
// Single-cycle result and carry/overflow for the non-shift ops; shift
// encodings fall through to pass-through of A with flags cleared.
module iter_alu_comb
  import iter_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  alu_op_t          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] result_o,
  output logic             carry_o,
  output logic             ovf_o
);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0] add_s;
  logic [WIDTH:0] sub_s;
  logic           add_ovf_s;
  logic           sub_ovf_s;
  logic           lt_s;
  logic           ltu_s;
  logic           eq_s;

  assign add_s     = {1'b0, a_i} + {1'b0, b_i};
  assign sub_s     = {1'b0, a_i} + {1'b0, ~b_i} + {{WIDTH{1'b0}}, 1'b1};
  assign add_ovf_s = (a_i[MSB] == b_i[MSB]) && (add_s[MSB] != a_i[MSB]);
  assign sub_ovf_s = (a_i[MSB] != b_i[MSB]) && (sub_s[MSB] != a_i[MSB]);
  // Signed less-than must survive overflow of the difference.
  assign lt_s      = sub_s[MSB] ^ sub_ovf_s;
  assign ltu_s     = ~sub_s[WIDTH];
  assign eq_s      = (a_i == b_i);

  // Opcode decode into result and ADD/SUB flags.
  always_comb begin
    result_o = a_i;
    carry_o  = 1'b0;
    ovf_o    = 1'b0;
    case (op_i)
      OP_ADD: begin
        result_o = add_s[MSB:0];
        carry_o  = add_s[WIDTH];
        ovf_o    = add_ovf_s;
      end
      OP_SUB: begin
        result_o = sub_s[MSB:0];
        carry_o  = sub_s[WIDTH];
        ovf_o    = sub_ovf_s;
      end
      OP_AND:    result_o = a_i & b_i;
      OP_OR:     result_o = a_i | b_i;
      OP_XOR:    result_o = a_i ^ b_i;
      OP_NOR:    result_o = ~(a_i | b_i);
      OP_NOT_A:  result_o = ~a_i;
      OP_PASS_A: result_o = a_i;
      OP_PASS_B: result_o = b_i;
      OP_LUI:    result_o = {b_i[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
      OP_SLT:    result_o = {{(WIDTH-1){1'b0}}, lt_s};
      OP_SGT:    result_o = {{(WIDTH-1){1'b0}}, ~lt_s & ~eq_s};
      OP_SLTU:   result_o = {{(WIDTH-1){1'b0}}, ltu_s};
      default:   result_o = a_i;
    endcase
  end
endmodule

// File: rtl/iter_alu.sv
// Registered ALU stage: single-cycle ops through iter_alu_comb, shifts
// iterated SHIFT_STEP bits per cycle, result held until the consumer takes it.
module iter_alu
  import iter_alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int SHIFT_STEP = 1
) (
  input logic       clk,
  input logic       rst_n,
  iter_alu_if.slave bus
);
  localparam int            SHW  = $clog2(WIDTH);
  localparam logic [SHW:0]  STEP = (SHW+1)'(SHIFT_STEP);

  state_t           state_q, state_d;
  alu_op_t          op_q, op_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [SHW-1:0]   rem_q, rem_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] comb_result_s;
  logic             comb_carry_s;
  logic             comb_ovf_s;
  logic [SHW-1:0]   shamt_s;
  logic [SHW:0]     k_s;
  logic [SHW-1:0]   rem_next_s;
  logic [WIDTH-1:0] shifted_s;

  iter_alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i     (bus.op),
    .a_i      (bus.a),
    .b_i      (bus.b),
    .result_o (comb_result_s),
    .carry_o  (comb_carry_s),
    .ovf_o    (comb_ovf_s)
  );

  assign shamt_s    = bus.b[SHW-1:0];
  assign rem_next_s = rem_q - k_s[SHW-1:0];

  // Step size for this iteration: the smaller of remaining count and SHIFT_STEP.
  always_comb begin
    if ({1'b0, rem_q} < STEP) begin
      k_s = {1'b0, rem_q};
    end else begin
      k_s = STEP;
    end
  end

  // One shift iteration; SRA refills from the working MSB, i.e. the original sign.
  always_comb begin
    shifted_s = work_q;
    case (op_q)
      OP_SLL:  shifted_s = work_q << k_s;
      OP_SRL:  shifted_s = work_q >> k_s;
      OP_SRA:  shifted_s = $signed(work_q) >>> k_s;
      default: shifted_s = work_q;
    endcase
  end

  // FSM next state and datapath next values.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    result_d = result_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d = bus.op;
          if (is_shift(bus.op) && (shamt_s != {SHW{1'b0}})) begin
            work_d  = bus.a;
            rem_d   = shamt_s;
            state_d = SHIFT;
          end else begin
            result_d = comb_result_s;
            carry_d  = comb_carry_s;
            ovf_d    = comb_ovf_s;
            zero_d   = (comb_result_s == {WIDTH{1'b0}});
            state_d  = HOLD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        work_d = shifted_s;
        rem_d  = rem_next_s;
        if (rem_next_s == {SHW{1'b0}}) begin
          result_d = shifted_s;
          zero_d   = (shifted_s == {WIDTH{1'b0}});
          carry_d  = 1'b0;
          ovf_d    = 1'b0;
          state_d  = HOLD;
        end else begin
          state_d = SHIFT;
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, working and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_ADD;
      work_q   <= {WIDTH{1'b0}};
      rem_q    <= {SHW{1'b0}};
      result_q <= {WIDTH{1'b0}};
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.carry     = carry_q;
  assign bus.ovf       = ovf_q;
  assign bus.illegal   = 1'b0;
endmodule

// File: tb/tb_iter_alu.sv
// Scoreboarded bench for iter_alu over four width/step configurations:
// directed corner cases, backpressure, mid-shift reset and throttled random ops.
module tb_iter_alu;
  import iter_alu_pkg::*;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        carry;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]       in_valid_v;
  logic [3:0]       out_ready_v;
  logic [3:0][3:0]  op_v;
  logic [3:0][31:0] a_v;
  logic [3:0][31:0] b_v;
  wire  [3:0][31:0] result_v;
  wire  [3:0]       in_ready_v;
  wire  [3:0]       out_valid_v;
  wire  [3:0]       zero_v;
  wire  [3:0]       carry_v;
  wire  [3:0]       ovf_v;
  wire  [3:0]       illegal_v;

  exp_t sb_q[$];
  int   lat_q[$];
  int   errors = 0;
  int   checks = 0;

  // dut0: W32/S1, dut1: W32/S4, dut2: W16/S2, dut3: W8/S1
  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int GW = (g < 2) ? 32 : (g == 2) ? 16 : 8;
    localparam int GS = (g == 1) ? 4 : (g == 2) ? 2 : 1;
    iter_alu_if #(.WIDTH(GW)) bus ();
    iter_alu #(.WIDTH(GW), .SHIFT_STEP(GS)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
    assign bus.in_valid   = in_valid_v[g];
    assign bus.op         = alu_op_t'(op_v[g]);
    assign bus.a          = a_v[g][GW-1:0];
    assign bus.b          = b_v[g][GW-1:0];
    assign bus.out_ready  = out_ready_v[g];
    assign result_v[g]    = 32'(bus.result);
    assign in_ready_v[g]  = bus.in_ready;
    assign out_valid_v[g] = bus.out_valid;
    assign zero_v[g]      = bus.zero;
    assign carry_v[g]     = bus.carry;
    assign ovf_v[g]       = bus.ovf;
    assign illegal_v[g]   = bus.illegal;
  end

  function automatic int wid(input int i);
    return (i < 2) ? 32 : (i == 2) ? 16 : 8;
  endfunction

  function automatic int stp(input int i);
    return (i == 1) ? 4 : (i == 2) ? 2 : 1;
  endfunction

  // Reference model in wide integer arithmetic with explicit signed values.
  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input int w);
    longint mask, am, bm, sa, sb, r, sr, hmask, smax, smin;
    int     sh;
    exp_t   e;
    mask  = (longint'(1) << w) - 64'sd1;
    hmask = (longint'(1) << (w / 2)) - 64'sd1;
    smax  = (longint'(1) << (w - 1)) - 64'sd1;
    smin  = -(longint'(1) << (w - 1));
    am    = longint'({32'd0, a}) & mask;
    bm    = longint'({32'd0, b}) & mask;
    sa    = (am > smax) ? am - (longint'(1) << w) : am;
    sb    = (bm > smax) ? bm - (longint'(1) << w) : bm;
    sh    = int'(bm % longint'(w));
    e.carry = 1'b0;
    e.ovf   = 1'b0;
    case (op)
      4'd0: begin r = am + bm; e.carry = (r > mask); sr = sa + sb; e.ovf = (sr > smax) || (sr < smin); end
      4'd1: begin r = am - bm; e.carry = (am >= bm); sr = sa - sb; e.ovf = (sr > smax) || (sr < smin); end
      4'd2:  r = am & bm;
      4'd3:  r = am | bm;
      4'd4:  r = am ^ bm;
      4'd5:  r = ~(am | bm);
      4'd6:  r = ~am;
      4'd7:  r = am;
      4'd8:  r = bm;
      4'd9:  r = (bm & hmask) << (w / 2);
      4'd10: r = (sa < sb) ? 64'sd1 : 64'sd0;
      4'd11: r = (sa > sb) ? 64'sd1 : 64'sd0;
      4'd12: r = (am < bm) ? 64'sd1 : 64'sd0;
      4'd13: r = am << sh;
      4'd14: r = am >> sh;
      4'd15: r = sa >>> sh;
      default: r = 64'sd0;
    endcase
    e.res  = 32'(r & mask);
    e.zero = (e.res == 32'd0);
    return e;
  endfunction

  task automatic check(input string tag, input int idx, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  task automatic check_last(input int idx, input logic [31:0] res, input logic z,
                            input logic c, input logic o);
    check("last_result", idx, result_v[idx], res);
    check("last_zero", idx, {31'd0, zero_v[idx]}, {31'd0, z});
    check("last_carry", idx, {31'd0, carry_v[idx]}, {31'd0, c});
    check("last_ovf", idx, {31'd0, ovf_v[idx]}, {31'd0, o});
  endtask

  // Drive one op, score latency, hold for 'hold' cycles under foreign in_valid, then drain.
  task automatic run_op(input int idx, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    exp_t e, got;
    int   w, st, sh, cyc, lat, exp_lat;
    w  = wid(idx);
    st = stp(idx);
    e  = model(op, a, b, w);
    sh = int'(b & 32'(w - 1));
    exp_lat = (op >= 4'd13 && sh != 0) ? 1 + (sh + st - 1) / st : 1;
    @(negedge clk);
    in_valid_v[idx] = 1'b1;
    op_v[idx] = op;
    a_v[idx]  = a;
    b_v[idx]  = b;
    cyc = 0;
    while (!in_ready_v[idx] && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("accept_bound", idx, 32'(cyc < 50), 32'd1);
    @(posedge clk);
    sb_q.push_back(e);
    lat_q.push_back(exp_lat);
    #1;
    in_valid_v[idx] = 1'b0;
    op_v[idx] = 4'($urandom);
    a_v[idx]  = $urandom;
    b_v[idx]  = $urandom;
    lat = 1;
    while (!out_valid_v[idx] && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency", idx, 32'(lat), 32'(lat_q.pop_front()));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      in_valid_v[idx] = 1'b1;
      op_v[idx] = 4'($urandom);
      a_v[idx]  = $urandom;
      check("busy_in_ready", idx, {31'd0, in_ready_v[idx]}, 32'd0);
      check("hold_stable", idx, result_v[idx], e.res);
    end
    @(negedge clk);
    in_valid_v[idx]  = 1'b0;
    out_ready_v[idx] = 1'b1;
    got = sb_q.pop_front();
    check("out_valid", idx, {31'd0, out_valid_v[idx]}, 32'd1);
    check("result", idx, result_v[idx], got.res);
    check("zero", idx, {31'd0, zero_v[idx]}, {31'd0, got.zero});
    check("carry", idx, {31'd0, carry_v[idx]}, {31'd0, got.carry});
    check("ovf", idx, {31'd0, ovf_v[idx]}, {31'd0, got.ovf});
    check("illegal", idx, {31'd0, illegal_v[idx]}, 32'd0);
    @(posedge clk);
    #1;
    out_ready_v[idx] = 1'b0;
    check("drain_valid", idx, {31'd0, out_valid_v[idx]}, 32'd0);
    check("drain_ready", idx, {31'd0, in_ready_v[idx]}, 32'd1);
  endtask

  initial begin
    int seen;
    rst_n       = 1'b0;
    in_valid_v  = 4'd0;
    out_ready_v = 4'd0;
    op_v        = '0;
    a_v         = '0;
    b_v         = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("rst_out_valid", i, {31'd0, out_valid_v[i]}, 32'd0);
      check_last(i, 32'd0, 1'b0, 1'b0, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) check("rst_in_ready", i, {31'd0, in_ready_v[i]}, 32'd1);

    run_op(0, OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 0);
    check_last(0, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
    run_op(0, OP_SUB, 32'd5, 32'd5, 0);
    check_last(0, 32'd0, 1'b1, 1'b1, 1'b0);
    run_op(0, OP_SLT, 32'h8000_0000, 32'd1, 0);
    check_last(0, 32'd1, 1'b0, 1'b0, 1'b0);
    run_op(0, OP_SGT, 32'h8000_0000, 32'd1, 0);
    check_last(0, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op(0, OP_SLTU, 32'h8000_0000, 32'd1, 0);
    check_last(0, 32'd0, 1'b1, 1'b0, 1'b0);
    run_op(0, OP_LUI, 32'h1234_5678, 32'h0000_ABCD, 0);
    check_last(0, 32'hABCD_0000, 1'b0, 1'b0, 1'b0);
    run_op(0, OP_SRA, 32'hF000_0000, 32'd4, 0);
    check_last(0, 32'hFF00_0000, 1'b0, 1'b0, 1'b0);
    run_op(1, OP_SRA, 32'hF000_0000, 32'd4, 0);
    check_last(1, 32'hFF00_0000, 1'b0, 1'b0, 1'b0);
    run_op(0, OP_SRA, 32'hF000_0000, 32'h0000_0020, 0);
    check_last(0, 32'hF000_0000, 1'b0, 1'b0, 1'b0);
    run_op(1, OP_SLL, 32'h0000_0001, 32'd31, 0);
    check_last(1, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
    run_op(3, OP_ADD, 32'h0000_007F, 32'd1, 0);
    check_last(3, 32'h0000_0080, 1'b0, 1'b0, 1'b1);
    run_op(3, OP_SUB, 32'd0, 32'd1, 0);
    check_last(3, 32'h0000_00FF, 1'b0, 1'b0, 1'b0);
    run_op(2, OP_LUI, 32'd0, 32'h0000_12AB, 0);
    check_last(2, 32'h0000_AB00, 1'b0, 1'b0, 1'b0);

    // Backpressure: ten stalled HOLD cycles with a competing in_valid.
    run_op(0, OP_XOR, 32'hA5A5_0F0F, 32'h0F0F_A5A5, 10);

    // Reset in the middle of a long shift must abort it for good.
    @(negedge clk);
    in_valid_v[0] = 1'b1;
    op_v[0] = OP_SLL;
    a_v[0]  = 32'h0000_0003;
    b_v[0]  = 32'd31;
    @(posedge clk);
    #1;
    in_valid_v[0] = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 0, {31'd0, out_valid_v[0]}, 32'd0);
    check_last(0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", 0, {31'd0, in_ready_v[0]}, 32'd1);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid_v[0]) seen = 1;
    end
    check("midrst_no_output", 0, 32'(seen), 32'd0);

    for (int n = 0; n < 50; n++) begin
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        run_op(i, 4'($urandom_range(0, 15)), $urandom, $urandom, int'($urandom_range(0, 3)));
      end
    end

    check("scoreboard_empty", 0, 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
